// File: rtl/restoring_divider_4bit_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default width.
package restoring_divider_4bit_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder cell shared with the combinational add/sub blocks.
module full_adder_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/restoring_divider_4bit_sub_stage.sv
// WIDTH+1-bit ripple subtractor (a - b) built from full adders with b inverted and carry-in 1.
module restoring_divider_4bit_sub_stage #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  output logic [WIDTH:0] o_diff,
  output logic           o_borrow
);

  logic [WIDTH:0]   w_b_n;
  logic [WIDTH+1:0] w_carry;

  assign w_b_n      = ~i_b;
  assign w_carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi <= WIDTH; gi++) begin : g_fa
      full_adder_1bit u_fa (
        .i_a    (i_a[gi]),
        .i_b    (w_b_n[gi]),
        .i_cin  (w_carry[gi]),
        .o_sum  (o_diff[gi]),
        .o_cout (w_carry[gi+1])
      );
    end
  endgenerate

  // No carry out of the top cell means a < b.
  assign o_borrow = ~w_carry[WIDTH+1];

endmodule

// File: rtl/restoring_divider_4bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a start/busy/done handshake.
module restoring_divider_4bit
  import restoring_divider_4bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t r_state, w_state_next;

  // Partial remainder stays below the divisor between iterations, so its top bit
  // is always zero once stored; only the shifted trial value needs WIDTH+1 bits.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_accept;
  logic             w_zero_div;
  logic             w_last;
  logic [WIDTH:0]   w_r_shift;
  logic [WIDTH:0]   w_t;
  logic             w_borrow;
  logic             w_restore;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_zero_div = (divisor == '0);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_r_shift  = {r_rem, r_q[WIDTH-1]};

  restoring_divider_4bit_sub_stage #(
    .WIDTH (WIDTH)
  ) u_sub (
    .i_a      (w_r_shift),
    .i_b      ({1'b0, r_d}),
    .o_diff   (w_t),
    .o_borrow (w_borrow)
  );

  // Sign bit and borrow agree while R < D; either marks a negative trial.
  assign w_restore = w_t[WIDTH] | w_borrow;
  assign w_r_next  = w_restore ? w_r_shift[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign w_q_next  = {r_q[WIDTH-2:0], ~w_restore};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        done = (r_state == DONE);
        if (start) begin
          w_state_next = w_zero_div ? DONE : CALC;
        end else begin
          w_state_next = IDLE;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      if (w_zero_div) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
        r_dbz       <= 1'b1;
      end else begin
        r_rem <= '0;
        r_q   <= dividend;
        r_d   <= divisor;
        r_cnt <= '0;
        r_dbz <= 1'b0;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_r_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_r_next;
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_restoring_divider_4bit.sv
// Self-checking bench: directed corner sequences, a vector table and a full operand sweep.
module tb_restoring_divider_4bit;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int   n_pass;
  int   n_total;
  exp_t sb_q[$];
  vec_t vecs[12];

  restoring_divider_4bit #(
    .WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] q, input logic [3:0] r, input logic dbz);
    exp_t e;
    e.q = q;
    e.r = r;
    e.dbz = dbz;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb_q.push_back(e);
  endtask

  // Clocks from the accepting edge until done; reports edge count and busy cycles.
  task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
    int  lat;
    int  busy_cyc;
    bit  seen;
    lat = 0;
    busy_cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (i == 0) start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_latency"}, seen ? lat : -1, exp_lat);
    check({name, "_busy_cycles"}, busy_cyc, exp_busy);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(posedge clk) begin
    #1;
    if (done) begin
      check("busy_with_done", int'(busy), 0);
      check("done_has_request", int'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        $display("done: q=%0d r=%0d dbz=%0d (want q=%0d r=%0d dbz=%0d)",
                 quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        check("quotient", int'(quotient), int'(e.q));
        check("remainder", int'(remainder), int'(e.r));
        check("div_by_zero", int'(div_by_zero), int'(e.dbz));
      end
    end
  end

  initial begin
    int lat;
    bit seen;
    logic [3:0] eq;
    logic [3:0] er;

    vecs[0]  = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, dbz: 1'b0};
    vecs[1]  = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dbz: 1'b0};
    vecs[2]  = '{a: 4'd3,  b: 4'd7,  q: 4'd0,  r: 4'd3, dbz: 1'b0};
    vecs[3]  = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, dbz: 1'b1};
    vecs[4]  = '{a: 4'd8,  b: 4'd2,  q: 4'd4,  r: 4'd0, dbz: 1'b0};
    vecs[5]  = '{a: 4'd14, b: 4'd3,  q: 4'd4,  r: 4'd2, dbz: 1'b0};
    vecs[6]  = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dbz: 1'b0};
    vecs[7]  = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dbz: 1'b0};
    vecs[8]  = '{a: 4'd7,  b: 4'd2,  q: 4'd3,  r: 4'd1, dbz: 1'b0};
    vecs[9]  = '{a: 4'd15, b: 4'd4,  q: 4'd3,  r: 4'd3, dbz: 1'b0};
    vecs[10] = '{a: 4'd1,  b: 4'd15, q: 4'd0,  r: 4'd1, dbz: 1'b0};
    vecs[11] = '{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0, dbz: 1'b1};

    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    tick();
    tick();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    tick();

    // 13 / 3 with a single-cycle start pulse
    start_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    wait_done("13div3", 5, 4);
    tick();

    // back-to-back: second start issued in the first done cycle
    start_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    wait_done("15div1", 5, 4);
    start_op(4'd3, 4'd7, 4'd0, 4'd3, 1'b0);
    wait_done("3div7_b2b", 5, 4);
    tick();

    // divide by zero, then a normal op clears the flag
    start_op(4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
    wait_done("9div0", 1, 0);
    tick();
    start_op(4'd8, 4'd2, 4'd4, 4'd0, 1'b0);
    wait_done("8div2", 5, 4);
    tick();
    check("dbz_cleared_held", int'(div_by_zero), 0);

    // start held high with new operands during busy must be ignored
    start_op(4'd12, 4'd5, 4'd2, 4'd2, 1'b0);
    tick();
    lat = 1;
    seen = 1'b0;
    dividend = 4'd1;
    divisor = 4'd1;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
        break;
      end
    end
    check("held_start_latency", seen ? lat : -1, 5);
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("held_quotient_kept", int'(quotient), 2);
    check("held_remainder_kept", int'(remainder), 2);

    // reset on the second CALC cycle aborts with no done
    start_op(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    sb_q.delete();
    tick();
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_dbz", int'(div_by_zero), 0);
    for (int i = 0; i < 8; i++) tick();
    start_op(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);
    wait_done("14div3_after_abort", 5, 4);
    tick();

    // vector table
    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
      wait_done($sformatf("vec%0d", i), (vecs[i].b == 4'd0) ? 1 : 5,
                (vecs[i].b == 4'd0) ? 0 : 4);
      tick();
    end

    // exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 4'hF;
          er = 4'(a);
        end else begin
          eq = 4'(a / b);
          er = 4'(a % b);
        end
        start_op(4'(a), 4'(b), eq, er, (b == 0));
        wait_done($sformatf("sweep_%0d_%0d", a, b), (b == 0) ? 1 : 5, (b == 0) ? 0 : 4);
        if (b != 0) begin
          check($sformatf("invariant_%0d_%0d", a, b), int'(quotient) * b + int'(remainder), a);
          check($sformatf("rem_lt_div_%0d_%0d", a, b), int'(int'(remainder) < b), 1);
        end
      end
    end

    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
